// File: rtl/pipe_addsub_pkg.sv
// Shared constants and helpers for the pipelined add/sub unit.
package pipe_addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Upper bound on WIDTH for the saturation constant helpers.
    localparam int unsigned MAX_W = 1024;

    function automatic int unsigned slice_w(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

    function automatic logic [MAX_W-1:0] signed_max(input int unsigned width);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < width - 1; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] signed_min(input int unsigned width);
        logic [MAX_W-1:0] r;
        r = '0;
        r[width-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/pipe_addsub_slice.sv
// Combinational SW-bit adder slice with carry in/out.
module addsub_slice #(
    parameter int unsigned SW = 16
) (
    input  logic [SW-1:0] x,
    input  logic [SW-1:0] y,
    input  logic          cin,
    output logic [SW-1:0] s,
    output logic          cout
);

    assign {cout, s} = {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, cin};

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor, one carry-chain slice per stage,
// valid/ready handshake with global stall, overflow/zero flags, optional saturation.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 4,
    parameter bit          SAT_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned SW = slice_w(WIDTH, STAGES);
    localparam logic [MAX_W-1:0] L_SMAX_X = signed_max(WIDTH);
    localparam logic [MAX_W-1:0] L_SMIN_X = signed_min(WIDTH);

    if ((STAGES == 0) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
        $error("pipe_addsub: WIDTH must be a non-zero multiple of STAGES");
    end

    logic [WIDTH-1:0] w_smax;
    logic [WIDTH-1:0] w_smin;
    logic             w_adv;

    logic             r_out_vld;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ovf;
    logic             r_zero;

    // Stage-k inputs. w_ar packs finished result slices below k*SW and the
    // still-unadded A slices above; w_b holds B' shifted so slice k sits at bit 0.
    logic [WIDTH-1:0] w_ar  [STAGES];
    logic [WIDTH-1:0] w_b   [STAGES];
    logic             w_cin [STAGES];
    logic             w_vld [STAGES];

    assign w_smax    = L_SMAX_X[WIDTH-1:0];
    assign w_smin    = L_SMIN_X[WIDTH-1:0];
    assign w_adv     = !r_out_vld || out_ready;
    assign in_ready  = w_adv;

    assign out_valid = r_out_vld;
    assign sum       = r_sum;
    assign carry     = r_carry;
    assign overflow  = r_ovf;
    assign zero      = r_zero;

    assign w_ar[0]  = a;
    assign w_b[0]   = (mode == MODE_SUB) ? ~b : b;
    assign w_cin[0] = mode;
    assign w_vld[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic [SW-1:0]    w_s;
        logic             w_co;
        logic [WIDTH-1:0] w_arn;

        addsub_slice #(.SW(SW)) u_slice (
            .x    (w_ar[k][k*SW +: SW]),
            .y    (w_b[k][SW-1:0]),
            .cin  (w_cin[k]),
            .s    (w_s),
            .cout (w_co)
        );

        always_comb begin
            w_arn               = w_ar[k];
            w_arn[k*SW +: SW]   = w_s;
        end

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] r_ar;
            logic [WIDTH-1:0] r_b;
            logic             r_cy;
            logic             r_vld;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= 1'b0;
                    r_ar  <= '0;
                    r_b   <= '0;
                    r_cy  <= 1'b0;
                end else if (w_adv) begin
                    r_vld <= w_vld[k];
                    r_ar  <= w_arn;
                    r_b   <= w_b[k] >> SW;
                    r_cy  <= w_co;
                end
            end

            assign w_ar[k+1]  = r_ar;
            assign w_b[k+1]   = r_b;
            assign w_cin[k+1] = r_cy;
            assign w_vld[k+1] = r_vld;
        end else begin : g_last
            logic             w_sa;
            logic             w_sb;
            logic             w_ovf;
            logic [WIDTH-1:0] w_fin;

            assign w_sa  = w_ar[k][WIDTH-1];
            assign w_sb  = w_b[k][SW-1];
            assign w_ovf = (w_sa == w_sb) && (w_arn[WIDTH-1] != w_sa);
            assign w_fin = (SAT_EN && w_ovf) ? (w_sa ? w_smin : w_smax) : w_arn;

            // Result registers load only with a valid op so bubbles leave flags untouched.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_vld <= 1'b0;
                    r_sum     <= '0;
                    r_carry   <= 1'b0;
                    r_ovf     <= 1'b0;
                    r_zero    <= 1'b0;
                end else if (w_adv) begin
                    r_out_vld <= w_vld[k];
                    if (w_vld[k]) begin
                        r_sum   <= w_fin;
                        r_carry <= w_co;
                        r_ovf   <= w_ovf;
                        r_zero  <= (w_fin == '0);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed self-checking bench for pipe_addsub (STAGES 4/1/8, SAT_EN 0/1).
module tb_pipe_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] a;
    logic [63:0] b;
    logic        mode;
    logic        out_ready;

    logic        m_in_ready, m_out_valid, m_carry, m_ovf, m_zero;
    logic [63:0] m_sum;
    logic        t_in_ready, t_out_valid, t_carry, t_ovf, t_zero;
    logic [63:0] t_sum;
    logic        p_in_ready, p_out_valid, p_carry, p_ovf, p_zero;
    logic [63:0] p_sum;
    logic        q_in_ready, q_out_valid, q_carry, q_ovf, q_zero;
    logic [63:0] q_sum;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipe_addsub #(.WIDTH(64), .STAGES(4), .SAT_EN(1'b0)) u_main (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(m_out_valid), .out_ready(out_ready),
        .sum(m_sum), .carry(m_carry), .overflow(m_ovf), .zero(m_zero));

    pipe_addsub #(.WIDTH(64), .STAGES(4), .SAT_EN(1'b1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(t_out_valid), .out_ready(out_ready),
        .sum(t_sum), .carry(t_carry), .overflow(t_ovf), .zero(t_zero));

    pipe_addsub #(.WIDTH(64), .STAGES(1), .SAT_EN(1'b0)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(p_in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(p_out_valid), .out_ready(out_ready),
        .sum(p_sum), .carry(p_carry), .overflow(p_ovf), .zero(p_zero));

    pipe_addsub #(.WIDTH(64), .STAGES(8), .SAT_EN(1'b0)) u_s8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(q_in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(q_out_valid), .out_ready(out_ready),
        .sum(q_sum), .carry(q_carry), .overflow(q_ovf), .zero(q_zero));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        m;
        logic [63:0] s;
        logic [63:0] ss;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    vec_t vt [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        held_v;
        logic [63:0] held_s;
        int          tx, rx, cyc;
        logic        seen;

        vt[0] = '{64'hfff, 64'hffff, 1'b0, 64'h10ffe, 64'h10ffe, 1'b0, 1'b0, 1'b0};
        vt[1] = '{64'd7, 64'd5, 1'b1, 64'd2, 64'd2, 1'b1, 1'b0, 1'b0};
        vt[2] = '{64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vt[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b1};
        vt[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000,
                  64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", m_out_valid, 0);
        chk("rst_sum", m_sum, 0);
        chk("rst_carry", m_carry, 0);
        chk("rst_ovf", m_ovf, 0);
        chk("rst_zero", m_zero, 0);
        chk("rst_in_ready", m_in_ready, 1);

        // Single ops, pipelines drained between vectors.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = vt[i].a; b = vt[i].b; mode = vt[i].m;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    in_valid = 1'b0;
                    chk($sformatf("v%0d_s1_valid", i), p_out_valid, 1);
                    chk($sformatf("v%0d_s1_sum", i), p_sum, vt[i].s);
                    chk($sformatf("v%0d_s1_carry", i), p_carry, vt[i].c);
                end
                if (c == 3) chk($sformatf("v%0d_early_valid", i), m_out_valid, 0);
                if (c == 4) begin
                    chk($sformatf("v%0d_valid", i), m_out_valid, 1);
                    chk($sformatf("v%0d_sum", i), m_sum, vt[i].s);
                    chk($sformatf("v%0d_carry", i), m_carry, vt[i].c);
                    chk($sformatf("v%0d_ovf", i), m_ovf, vt[i].o);
                    chk($sformatf("v%0d_zero", i), m_zero, vt[i].z);
                    chk($sformatf("v%0d_sat_sum", i), t_sum, vt[i].ss);
                    chk($sformatf("v%0d_sat_ovf", i), t_ovf, vt[i].o);
                end
                if (c == 5) chk($sformatf("v%0d_bubble", i), m_out_valid, 0);
                if (c == 7) chk($sformatf("v%0d_s8_early", i), q_out_valid, 0);
                if (c == 8) begin
                    chk($sformatf("v%0d_s8_valid", i), q_out_valid, 1);
                    chk($sformatf("v%0d_s8_sum", i), q_sum, vt[i].s);
                    chk($sformatf("v%0d_s8_zero", i), q_zero, vt[i].z);
                end
            end
        end

        // Backpressure: 8 back-to-back adds, consumer stalls cycles 6..8.
        tx = 0; rx = 0; cyc = 0; held_v = 1'b0; held_s = '0; mode = 1'b0;
        while (rx < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 8);
            #1;
            if (held_v) begin
                chk("bp_hold_valid", m_out_valid, 1);
                chk("bp_hold_sum", m_sum, held_s);
            end
            held_v = m_out_valid && !out_ready;
            held_s = m_sum;
            if (held_v) chk("bp_in_ready_low", m_in_ready, 0);
            if (m_out_valid && out_ready) begin
                chk($sformatf("bp_res%0d", rx), m_sum, 64'(2 * rx));
                rx++;
            end
            in_valid = (tx < 8);
            a = 64'(tx); b = 64'(tx);
            if (in_valid && m_in_ready) tx++;
            cyc++;
        end
        chk("bp_count", 64'(rx), 64'd8);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(negedge clk);

        // Reset with three ops in flight.
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; a = 64'(i); b = 64'(i); mode = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_out_valid", m_out_valid, 0);
        chk("mrst_sum", m_sum, 0);
        chk("mrst_in_ready", m_in_ready, 1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (m_out_valid) seen = 1'b1;
        end
        chk("mrst_no_stale", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
